// File: rtl/hi_lo_muldiv_unit_if.sv
// ============================================================================
// Module      : hi_lo_muldiv_unit_if
// Description : Operand/handshake bundle between the EX stage and the HI/LO
//               multiply-divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hi_lo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             StartIn;
  logic [2:0]       OpIn;
  logic [WIDTH-1:0] OperandAIn;
  logic [WIDTH-1:0] OperandBIn;
  logic             FlushIn;
  logic             HiLoSel;
  logic             BusyOut;
  logic             DoneOut;
  logic             DivByZeroOut;
  logic [WIDTH-1:0] HiOut;
  logic [WIDTH-1:0] LoOut;
  logic [WIDTH-1:0] HiLoOut;

  modport master (
    output StartIn, OpIn, OperandAIn, OperandBIn, FlushIn, HiLoSel,
    input  BusyOut, DoneOut, DivByZeroOut, HiOut, LoOut, HiLoOut
  );

  modport slave (
    input  StartIn, OpIn, OperandAIn, OperandBIn, FlushIn, HiLoSel,
    output BusyOut, DoneOut, DivByZeroOut, HiOut, LoOut, HiLoOut
  );
endinterface

`default_nettype wire

// File: rtl/hi_lo_muldiv_unit.sv
// ============================================================================
// Module      : hi_lo_muldiv_unit
// Description : HI/LO register pair with iterative radix-2 multiply, MADD/MSUB
//               and restoring divide. Divider built only with HILO_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hi_lo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input wire logic           Clk,
  input wire logic           Reset,
  hi_lo_muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MSUB, OP_MTHI, OP_MTLO
  } op_t;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t             state_q;
  op_t                op_q;
  logic               neg_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q, dbz_q;

  op_t                w_op;
  logic               w_signed;
  logic [WIDTH-1:0]   w_a_abs, w_b_abs;
  logic [WIDTH:0]     mul_sum_d;
  logic [2*WIDTH-1:0] mul_step_d;
  logic [2*WIDTH-1:0] mag_d, fix_d;

  assign w_op     = op_t'(bus.OpIn);
  assign w_signed = (w_op == OP_MULT) || (w_op == OP_DIV) ||
                    (w_op == OP_MADD) || (w_op == OP_MSUB);
  assign w_a_abs  = (w_signed && bus.OperandAIn[WIDTH-1]) ? -bus.OperandAIn : bus.OperandAIn;
  assign w_b_abs  = (w_signed && bus.OperandBIn[WIDTH-1]) ? -bus.OperandBIn : bus.OperandBIn;

  // Shift-add: multiplier sits in the low half and shifts out as the product fills in.
  assign mul_sum_d  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_step_d = {mul_sum_d, prod_q[WIDTH-1:1]};

`ifdef HILO_DIV_EN
  logic               sa_q;
  logic [WIDTH:0]     div_shift_d, div_diff_d;
  logic [2*WIDTH-1:0] div_step_d;

  // Restoring step: {remainder, dividend} shifts left, quotient bits enter at bit 0.
  assign div_shift_d = prod_q[2*WIDTH-1:WIDTH-1];
  assign div_diff_d  = div_shift_d - {1'b0, opnd_q};
  assign div_step_d  = div_diff_d[WIDTH]
                     ? {div_shift_d[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
                     : {div_diff_d[WIDTH-1:0],  prod_q[WIDTH-2:0], 1'b1};
`endif

  always_comb begin
    mag_d = neg_q ? -prod_q : prod_q;
    fix_d = mag_d;
    case (op_q)
      OP_MADD: fix_d = {hi_q, lo_q} + mag_d;
      OP_MSUB: fix_d = {hi_q, lo_q} - mag_d;
`ifdef HILO_DIV_EN
      OP_DIV, OP_DIVU: begin
        fix_d[WIDTH-1:0]       = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
        fix_d[2*WIDTH-1:WIDTH] = sa_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULT;
      neg_q   <= 1'b0;
      opnd_q  <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef HILO_DIV_EN
      sa_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          if (bus.StartIn && !bus.FlushIn) begin
            case (w_op)
              OP_MTHI: hi_q <= bus.OperandAIn;
              OP_MTLO: lo_q <= bus.OperandAIn;
              OP_DIV, OP_DIVU: begin
`ifdef HILO_DIV_EN
                if (bus.OperandBIn == '0) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  dbz_q   <= 1'b1;
                end else begin
                  state_q <= S_DIV;
                  busy_q  <= 1'b1;
                  op_q    <= w_op;
                  opnd_q  <= w_b_abs;
                  prod_q  <= {{WIDTH{1'b0}}, w_a_abs};
                  cnt_q   <= '0;
                  neg_q   <= w_signed && (bus.OperandAIn[WIDTH-1] ^ bus.OperandBIn[WIDTH-1]);
                  sa_q    <= w_signed && bus.OperandAIn[WIDTH-1];
                end
`else
                state_q <= S_DONE;
                done_q  <= 1'b1;
`endif
              end
              default: begin
                state_q <= S_MUL;
                busy_q  <= 1'b1;
                op_q    <= w_op;
                opnd_q  <= w_a_abs;
                prod_q  <= {{WIDTH{1'b0}}, w_b_abs};
                cnt_q   <= '0;
                neg_q   <= w_signed && (bus.OperandAIn[WIDTH-1] ^ bus.OperandBIn[WIDTH-1]);
              end
            endcase
          end
        end
        S_MUL: begin
          if (bus.FlushIn) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            prod_q <= mul_step_d;
            cnt_q  <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
          end
        end
`ifdef HILO_DIV_EN
        S_DIV: begin
          if (bus.FlushIn) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            prod_q <= div_step_d;
            cnt_q  <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
          end
        end
`endif
        S_FIX: begin
          busy_q <= 1'b0;
          if (bus.FlushIn) begin
            state_q <= S_IDLE;
          end else begin
            {hi_q, lo_q} <= fix_d;
            done_q       <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.BusyOut      = busy_q;
  assign bus.DoneOut      = done_q;
  assign bus.DivByZeroOut = dbz_q;
  assign bus.HiOut        = hi_q;
  assign bus.LoOut        = lo_q;
  assign bus.HiLoOut      = bus.HiLoSel ? hi_q : lo_q;

endmodule

`default_nettype wire

// File: tb/tb_hi_lo_muldiv_unit.sv
// ============================================================================
// Module      : tb_hi_lo_muldiv_unit
// Description : Scoreboard bench for hi_lo_muldiv_unit (WIDTH=32); follows
//               HILO_DIV_EN to pick the divide behaviour of the model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hi_lo_muldiv_unit;

  localparam int W = 32;
  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3,
                         MADD = 3'd4, MSUB = 3'd5, MTHI = 3'd6, MTLO = 3'd7;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           due;
    int           busy;
  } exp_t;

  logic   Clk = 1'b0;
  logic   Reset = 1'b0;
  int     cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  exp_t   sb[$];
  logic [W-1:0] m_hi = '0, m_lo = '0;

  hi_lo_muldiv_unit_if #(.WIDTH(W)) bus ();

  hi_lo_muldiv_unit #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: plain 64-bit arithmetic on the architectural operation.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, b,
                                input logic [W-1:0] hi_in, lo_in,
                                output logic [W-1:0] hi_out, lo_out,
                                output logic dz, output int lat);
    longint sa, sb_, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    hi_out = hi_in;
    lo_out = lo_in;
    dz = 1'b0;
    lat = W + 1;
    p = {hi_in, lo_in};
    case (op)
      MULT:  p = 64'(sa * sb_);
      MULTU: p = {32'b0, a} * {32'b0, b};
      MADD:  p = p + 64'(sa * sb_);
      MSUB:  p = p - 64'(sa * sb_);
      default: ;
    endcase
    case (op)
      MULT, MULTU, MADD, MSUB: {hi_out, lo_out} = p;
      DIV, DIVU: begin
`ifdef HILO_DIV_EN
        if (b == '0) begin
          dz = 1'b1;
          lat = 0;
        end else if (op == DIV) begin
          lo_out = 32'(sa / sb_);
          hi_out = 32'(sa % sb_);
        end else begin
          lo_out = 32'(ua / ub);
          hi_out = 32'(ua % ub);
        end
`else
        lat = 0;
`endif
      end
      MTHI: begin hi_out = a; lat = -1; end
      default: begin lo_out = a; lat = -1; end
    endcase
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (bus.BusyOut === 1'b1) begin
      @(negedge Clk);
      n++;
      if (n > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL idle_timeout: BusyOut still %b after %0d cycles, required 0", bus.BusyOut, n);
        break;
      end
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, b);
    logic [W-1:0] nh, nl;
    logic dz;
    int lat;
    exp_t e;
    wait_idle();
    model(op, a, b, m_hi, m_lo, nh, nl, dz, lat);
    bus.StartIn    = 1'b1;
    bus.OpIn       = op;
    bus.OperandAIn = a;
    bus.OperandBIn = b;
    bus.HiLoSel    = 1'($urandom_range(0, 1));
    @(posedge Clk);
    #1;
    bus.StartIn = 1'b0;
    if (lat >= 0) begin
      e.hi = nh; e.lo = nl; e.dbz = dz;
      e.due = cyc + lat;
      e.busy = (lat == 0) ? 0 : W + 1;
      sb.push_back(e);
    end
    m_hi = nh;
    m_lo = nl;
    @(negedge Clk);
    if (lat < 0) begin
      check("mt_hi", bus.HiOut, m_hi);
      check("mt_lo", bus.LoOut, m_lo);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every completion pops one expectation and is checked against it.
  initial begin
    int run;
    exp_t e;
    run = 0;
    forever begin
      @(negedge Clk);
      if (Reset !== 1'b1) begin
        run = 0;
        continue;
      end
      if (bus.DoneOut === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: DoneOut=1 at cycle %0d, required no completion", cyc);
        end else begin
          e = sb.pop_front();
          check("done_cycle", 64'(cyc), 64'(e.due));
          check("busy_len", 64'(run), 64'(e.busy));
          check("hi", bus.HiOut, e.hi);
          check("lo", bus.LoOut, e.lo);
          check("divbyzero", bus.DivByZeroOut, e.dbz);
          check("hilo_mux", bus.HiLoOut, bus.HiLoSel ? e.hi : e.lo);
        end
        run = 0;
      end else if (bus.BusyOut === 1'b1) begin
        run++;
      end else begin
        run = 0;
      end
    end
  end

  initial begin
    bus.StartIn = 1'b0; bus.OpIn = '0; bus.OperandAIn = '0; bus.OperandBIn = '0;
    bus.FlushIn = 1'b0; bus.HiLoSel = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_hi", bus.HiOut, 0);
    check("rst_lo", bus.LoOut, 0);
    check("rst_busy", bus.BusyOut, 0);
    check("rst_done", bus.DoneOut, 0);
    Reset = 1'b1;
    @(negedge Clk);

    issue(MULT, -32'sd3, 32'd7);
    wait_idle();
    check("mult_hi_const", bus.HiOut, 32'hFFFF_FFFF);
    check("mult_lo_const", bus.LoOut, 32'hFFFF_FFEB);

`ifdef HILO_DIV_EN
    issue(DIVU, 32'd100, 32'd7);
    wait_idle();
    check("divu_lo_const", bus.LoOut, 32'h0000_000E);
    check("divu_hi_const", bus.HiOut, 32'h0000_0002);
    issue(DIV, -32'sd7, 32'd2);
    wait_idle();
    check("div_lo_const", bus.LoOut, 32'hFFFF_FFFD);
    check("div_hi_const", bus.HiOut, 32'hFFFF_FFFF);
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
`endif
    issue(MTHI, 32'h1234, 32'd0);
    issue(DIV, 32'd5, 32'd0);
    issue(MTLO, 32'd5, 32'd0);
    check("div0_hi_kept", bus.HiOut, 32'h1234);
    issue(MTHI, 32'd0, 32'd0);
    issue(MADD, 32'd3, 32'd4);
    wait_idle();
    check("madd_lo_const", bus.LoOut, 32'h11);
    check("madd_hi_const", bus.HiOut, 32'h0);
    issue(MSUB, 32'd1, 32'd18);
    wait_idle();
    check("msub_hilo_const", {bus.HiOut, bus.LoOut}, 64'hFFFF_FFFF_FFFF_FFFF);

    // Stray start mid-op, then flush: no completion, HI/LO untouched.
    @(negedge Clk);
    bus.StartIn = 1'b1; bus.OpIn = MULT; bus.OperandAIn = $urandom; bus.OperandBIn = $urandom;
    @(negedge Clk);
    bus.StartIn = 1'b0;
    repeat (4) @(negedge Clk);
    bus.StartIn = 1'b1; bus.OpIn = MTHI; bus.OperandAIn = 32'hDEAD_BEEF;
    @(negedge Clk);
    bus.StartIn = 1'b0;
    check("busy_mid_op", bus.BusyOut, 1);
    check("start_ignored_hi", bus.HiOut, m_hi);
    repeat (4) @(negedge Clk);
    bus.FlushIn = 1'b1;
    @(negedge Clk);
    bus.FlushIn = 1'b0;
    check("flush_busy", bus.BusyOut, 0);
    check("flush_hi", bus.HiOut, m_hi);
    check("flush_lo", bus.LoOut, m_lo);
    bus.FlushIn = 1'b1; bus.StartIn = 1'b1; bus.OpIn = MTLO; bus.OperandAIn = 32'h5555_0000;
    @(negedge Clk);
    bus.FlushIn = 1'b0; bus.StartIn = 1'b0;
    check("flush_wins_lo", bus.LoOut, m_lo);
    repeat (40) @(negedge Clk);

    // Asynchronous reset in the middle of a long operation.
`ifdef HILO_DIV_EN
    issue(DIV, 32'd1000, 32'd3);
`else
    issue(MULT, 32'd1000, 32'd3);
`endif
    repeat (5) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("arst_hi", bus.HiOut, 0);
    check("arst_lo", bus.LoOut, 0);
    check("arst_busy", bus.BusyOut, 0);
    check("arst_done", bus.DoneOut, 0);
    check("arst_dbz", bus.DivByZeroOut, 0);
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    issue(MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_idle();
    check("multu_hi_const", bus.HiOut, 32'h1);
    check("multu_lo_const", bus.LoOut, 32'hFFFF_FFFE);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      issue(op, pick(), pick());
    end
    wait_idle();
    repeat (3) @(negedge Clk);
    check("scoreboard_drained", 64'(sb.size()), 0);
    check("final_hi", bus.HiOut, m_hi);
    check("final_lo", bus.LoOut, m_lo);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
